// File: rtl/ryuki_datatypes.sv
// Shared datatypes for the instruction-fetch responder: response-queue entry
// layout, grant FSM states and a countdown helper.
package ryuki_datatypes;

  // Widest instruction word a response entry can carry; DATA_WIDTH must not exceed it.
  localparam int RESP_DATA_W = 32;
  localparam int COUNTDOWN_W = 3;

  typedef logic [COUNTDOWN_W-1:0] countdown_t;

  typedef struct packed {
    logic [RESP_DATA_W-1:0] data;
    countdown_t             countdown;
  } resp_entry_t;

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_COUNT = 2'd1,
    GNT_GRANT = 2'd2
  } gnt_state_e;

  function automatic countdown_t countdown_dec(input countdown_t c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

endpackage

// File: rtl/instr_mem_responder_resp_queue.sv
// In-order response queue: every stored countdown ticks down once per cycle,
// and the head is presented with its current countdown for the owner to pop.
module resp_queue
  import ryuki_datatypes::*;
#(
  parameter int depth = 2,
  parameter int width = RESP_DATA_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  resp_entry_t push_entry,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output resp_entry_t head
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int CNT_W = $clog2(depth + 1);

  logic [width-1:0] data_q [depth];
  logic [width-1:0] data_d [depth];
  countdown_t       cd_q   [depth];
  countdown_t       cd_d   [depth];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    for (int i = 0; i < depth; i++) begin
      cd_d[i] = countdown_dec(cd_q[i]);
    end
    // The grant cycle is the first counted cycle, so the new entry lands pre-decremented.
    if (push) begin
      data_d[wr_ptr_q] = push_entry.data[width-1:0];
      cd_d[wr_ptr_q]   = countdown_dec(push_entry.countdown);
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        data_q[i] <= '0;
        cd_q[i]   <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < depth; i++) begin
        data_q[i] <= data_d[i];
        cd_q[i]   <= cd_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == CNT_W'(depth));
  assign empty = (count_q == '0);
  assign head  = '{data: RESP_DATA_W'(data_q[rd_ptr_q]), countdown: cd_q[rd_ptr_q]};

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory model answering a req/gnt/rvalid fetch port with
// configurable grant latency, response latency and outstanding limit.
module instr_mem_responder
  import ryuki_datatypes::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_WORDS       = 1024,
  parameter int GNT_DELAY       = 0,
  parameter int RVALID_DELAY    = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_gnt,
  output logic                  instr_rvalid,
  output logic [DATA_WIDTH-1:0] instr_rdata,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [2:0]            outstanding
);

  localparam int                    IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ADDR_WIDTH'(MEM_WORDS - 1);
  localparam logic [2:0]            GNT_LAST  = 3'(GNT_DELAY - 1);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [IDX_W-1:0]      fetch_idx;
  logic [IDX_W-1:0]      load_idx;

  gnt_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  outstanding_q, outstanding_d;
  logic        q_full, q_empty;
  logic        rvalid, can_accept, gnt;
  resp_entry_t push_entry, head;

  // Byte addresses become word indices; bits above the memory depth wrap away.
  assign fetch_idx = IDX_W'((instr_addr >> 2) & WORD_MASK);
  assign load_idx  = IDX_W'((load_addr >> 2) & WORD_MASK);

  assign rvalid     = !q_empty && (head.countdown == '0);
  assign can_accept = !q_full || rvalid;

  always_comb begin
    gnt = 1'b0;
    if (GNT_DELAY == 0) begin
      gnt = !rst && instr_req && can_accept;
    end else begin
      gnt = (state_q == GNT_GRANT);
    end
  end

  // A request that has started counting can never hit a full queue, since
  // only this FSM issues grants.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      GNT_IDLE: begin
        if ((GNT_DELAY != 0) && instr_req && can_accept) begin
          if (GNT_DELAY == 1) begin
            state_d = GNT_GRANT;
          end else begin
            state_d = GNT_COUNT;
            cnt_d   = 3'd1;
          end
        end
      end
      GNT_COUNT: begin
        if (!instr_req) begin
          state_d = GNT_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == GNT_LAST) begin
          state_d = GNT_GRANT;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      GNT_GRANT: begin
        state_d = GNT_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = GNT_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q + 3'(gnt) - 3'(rvalid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= GNT_IDLE;
      cnt_q         <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Memory is read in the grant cycle, so a same-cycle load is not yet visible.
  assign push_entry = '{data: RESP_DATA_W'(mem_q[fetch_idx]),
                        countdown: countdown_t'(RVALID_DELAY)};

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_idx] <= load_data;
    end
  end

  resp_queue #(
    .depth (MAX_OUTSTANDING),
    .width (DATA_WIDTH)
  ) u_resp_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (gnt),
    .push_entry (push_entry),
    .pop        (rvalid),
    .full       (q_full),
    .empty      (q_empty),
    .head       (head)
  );

  assign instr_gnt    = gnt;
  assign instr_rvalid = rvalid;
  assign instr_rdata  = rvalid ? head.data[DATA_WIDTH-1:0] : '0;
  assign outstanding  = outstanding_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: four instances cover default timing, grant
// delay, outstanding limit and mid-flight reset.
module tb_instr_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic r_rst;

  // default-parameter instance
  logic        d_req, d_gnt, d_rvalid, d_load_en;
  logic [31:0] d_addr, d_rdata, d_load_addr, d_load_data;
  logic [2:0]  d_outstanding;
  // GNT_DELAY=2 instance
  logic        y_req, y_gnt, y_rvalid, y_load_en;
  logic [31:0] y_addr, y_rdata, y_load_addr, y_load_data;
  logic [2:0]  y_outstanding;
  // RVALID_DELAY=4, MAX_OUTSTANDING=2 instance
  logic        m_req, m_gnt, m_rvalid, m_load_en;
  logic [31:0] m_addr, m_rdata, m_load_addr, m_load_data;
  logic [2:0]  m_outstanding;
  // RVALID_DELAY=3 instance with its own reset
  logic        r_req, r_gnt, r_rvalid, r_load_en;
  logic [31:0] r_addr, r_rdata, r_load_addr, r_load_data;
  logic [2:0]  r_outstanding;

  instr_mem_responder u_def (
    .clk(clk), .rst(rst), .instr_req(d_req), .instr_addr(d_addr), .instr_gnt(d_gnt),
    .instr_rvalid(d_rvalid), .instr_rdata(d_rdata), .load_en(d_load_en),
    .load_addr(d_load_addr), .load_data(d_load_data), .outstanding(d_outstanding)
  );

  instr_mem_responder #(.GNT_DELAY(2)) u_dly (
    .clk(clk), .rst(rst), .instr_req(y_req), .instr_addr(y_addr), .instr_gnt(y_gnt),
    .instr_rvalid(y_rvalid), .instr_rdata(y_rdata), .load_en(y_load_en),
    .load_addr(y_load_addr), .load_data(y_load_data), .outstanding(y_outstanding)
  );

  instr_mem_responder #(.RVALID_DELAY(4), .MAX_OUTSTANDING(2)) u_max (
    .clk(clk), .rst(rst), .instr_req(m_req), .instr_addr(m_addr), .instr_gnt(m_gnt),
    .instr_rvalid(m_rvalid), .instr_rdata(m_rdata), .load_en(m_load_en),
    .load_addr(m_load_addr), .load_data(m_load_data), .outstanding(m_outstanding)
  );

  instr_mem_responder #(.RVALID_DELAY(3)) u_rst (
    .clk(clk), .rst(r_rst), .instr_req(r_req), .instr_addr(r_addr), .instr_gnt(r_gnt),
    .instr_rvalid(r_rvalid), .instr_rdata(r_rdata), .load_en(r_load_en),
    .load_addr(r_load_addr), .load_data(r_load_data), .outstanding(r_outstanding)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model_mem [1024];
  logic        sb_en = 1'b0;

  localparam logic [31:0] Y_WORD = 32'h5A5A_0001;

  function automatic int word_idx(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d_load(input logic [31:0] a, input logic [31:0] v);
    d_load_en   = 1'b1;
    d_load_addr = a;
    d_load_data = v;
    step();
    d_load_en = 1'b0;
    model_mem[word_idx(a)] = v;
  endtask

  // Scoreboard for the default instance: expected word queued at grant,
  // compared when the response comes back.
  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (d_rvalid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_rvalid: got rvalid with rdata=%h, required no response", d_rdata);
        end else begin
          logic [31:0] exp_word;
          exp_word = exp_q.pop_front();
          if (d_rdata !== exp_word) begin
            failures++;
            $display("FAIL sb_rdata: got %h, required %h", d_rdata, exp_word);
          end
        end
      end else begin
        checks++;
        if (d_rdata !== 32'h0) begin
          failures++;
          $display("FAIL sb_rdata_idle: got %h, required 00000000", d_rdata);
        end
      end
      if (d_gnt) exp_q.push_back(model_mem[word_idx(d_addr)]);
    end
  end

  task automatic test_reset();
    d_req = 1'b1;
    r_req = 1'b1;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt: got %b, required 0", d_gnt); end
    checks++;
    if (d_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b, required 0", d_rvalid); end
    checks++;
    if (d_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h, required 0", d_rdata); end
    checks++;
    if (d_outstanding !== 3'd0) begin failures++; $display("FAIL reset_outstanding: got %0d, required 0", d_outstanding); end
    checks++;
    if (r_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt_r: got %b, required 0", r_gnt); end
    d_req = 1'b0;
    r_req = 1'b0;
    step();
    rst   = 1'b0;
    r_rst = 1'b0;
    sb_en = 1'b1;
  endtask

  task automatic test_basic();
    d_load(32'h10, 32'hDEADBEEF);
    d_req  = 1'b1;
    d_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin failures++; $display("FAIL basic_gnt_c0: got %b, required 1", d_gnt); end
    step();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_rvalid_c1: got rvalid=%b rdata=%h, required 1 deadbeef", d_rvalid, d_rdata);
    end
    step();
  endtask

  task automatic test_wrap();
    d_load(32'h0, 32'h1234_5678);
    d_req  = 1'b1;
    d_addr = 32'h1003;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin failures++; $display("FAIL wrap_gnt: got %b, required 1", d_gnt); end
    step();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL wrap_rdata: got rvalid=%b rdata=%h, required 1 12345678", d_rvalid, d_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) d_load(32'h40 + 32'(4 * i), $urandom());
    for (int i = 0; i < 4; i++) begin
      logic [2:0] exp_out;
      exp_out = (i == 0) ? 3'd0 : 3'd1;
      d_req  = 1'b1;
      d_addr = 32'h40 + 32'(4 * i);
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt[%0d]: got %b, required 1", i, d_gnt); end
      checks++;
      if (d_outstanding !== exp_out) begin
        failures++;
        $display("FAIL b2b_outstanding[%0d]: got %0d, required %0d", i, d_outstanding, exp_out);
      end
      step();
    end
    d_req = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (d_outstanding !== 3'd0) begin failures++; $display("FAIL b2b_drain: got %0d, required 0", d_outstanding); end
    step();
  endtask

  task automatic test_load_collision();
    d_load(32'h20, 32'hCAFE_0008);
    d_req       = 1'b1;
    d_addr      = 32'h20;
    d_load_en   = 1'b1;
    d_load_addr = 32'h20;
    d_load_data = 32'h1;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin failures++; $display("FAIL collide_gnt: got %b, required 1", d_gnt); end
    step();
    d_load_en    = 1'b0;
    model_mem[8] = 32'h1;
    d_req        = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE_0008) begin
      failures++;
      $display("FAIL collide_old_data: got rvalid=%b rdata=%h, required 1 cafe0008", d_rvalid, d_rdata);
    end
    step();
    d_req = 1'b1;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin failures++; $display("FAIL collide_gnt2: got %b, required 1", d_gnt); end
    step();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h1) begin
      failures++;
      $display("FAIL collide_new_data: got rvalid=%b rdata=%h, required 1 00000001", d_rvalid, d_rdata);
    end
    step();
  endtask

  task automatic test_gnt_delay();
    logic [6:0] req_pat, gnt_pat, rv_pat;
    y_load_en   = 1'b1;
    y_load_addr = 32'h0;
    y_load_data = Y_WORD;
    step();
    y_load_en = 1'b0;
    y_addr    = 32'h0;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        req_pat = 7'b0000111; gnt_pat = 7'b0000100; rv_pat = 7'b0001000;
      end else begin
        req_pat = 7'b0111001; gnt_pat = 7'b0100000; rv_pat = 7'b1000000;
      end
      for (int c = 0; c < 7; c++) begin
        y_req = req_pat[c];
        @(negedge clk);
        checks++;
        if (y_gnt !== gnt_pat[c]) begin
          failures++;
          $display("FAIL dly_gnt s%0d c%0d: got %b, required %b", s, c, y_gnt, gnt_pat[c]);
        end
        checks++;
        if (y_rvalid !== rv_pat[c] || (rv_pat[c] && y_rdata !== Y_WORD)) begin
          failures++;
          $display("FAIL dly_rvalid s%0d c%0d: got %b/%h, required %b/%h", s, c, y_rvalid, y_rdata, rv_pat[c], Y_WORD);
        end
        step();
      end
    end
    y_req = 1'b0;
  endtask

  task automatic test_max_outstanding();
    logic [9:0] req_pat, gnt_pat, rv_pat;
    int         exp_out [10];
    req_pat = 10'b0000011111;
    gnt_pat = 10'b0000010011;
    rv_pat  = 10'b0100110000;
    exp_out = '{0, 1, 2, 2, 2, 2, 1, 1, 1, 0};
    m_addr  = 32'h0;
    for (int c = 0; c < 10; c++) begin
      m_req = req_pat[c];
      @(negedge clk);
      checks++;
      if (m_gnt !== gnt_pat[c]) begin
        failures++;
        $display("FAIL max_gnt c%0d: got %b, required %b", c, m_gnt, gnt_pat[c]);
      end
      checks++;
      if (m_rvalid !== rv_pat[c] || (!rv_pat[c] && m_rdata !== 32'h0)) begin
        failures++;
        $display("FAIL max_rvalid c%0d: got %b/%h, required %b", c, m_rvalid, m_rdata, rv_pat[c]);
      end
      checks++;
      if (m_outstanding !== 3'(exp_out[c])) begin
        failures++;
        $display("FAIL max_outstanding c%0d: got %0d, required %0d", c, m_outstanding, exp_out[c]);
      end
      step();
    end
    m_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int rv_seen;
    rv_seen = 0;
    r_req   = 1'b1;
    r_addr  = 32'h0;
    @(negedge clk);
    checks++;
    if (r_gnt !== 1'b1) begin failures++; $display("FAIL rstmid_gnt: got %b, required 1", r_gnt); end
    step();
    r_req = 1'b0;
    r_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (r_outstanding !== 3'd0) begin failures++; $display("FAIL rstmid_outstanding_in_rst: got %0d, required 0", r_outstanding); end
    step();
    step();
    r_rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (r_rvalid !== 1'b0) rv_seen++;
      step();
    end
    checks++;
    if (rv_seen != 0) begin failures++; $display("FAIL rstmid_rvalid: got %0d rvalid cycles, required 0", rv_seen); end
    @(negedge clk);
    checks++;
    if (r_outstanding !== 3'd0) begin failures++; $display("FAIL rstmid_outstanding: got %0d, required 0", r_outstanding); end
    step();
  endtask

  initial begin
    rst   = 1'b1;
    r_rst = 1'b1;
    d_req = 1'b0; d_addr = '0; d_load_en = 1'b0; d_load_addr = '0; d_load_data = '0;
    y_req = 1'b0; y_addr = '0; y_load_en = 1'b0; y_load_addr = '0; y_load_data = '0;
    m_req = 1'b0; m_addr = '0; m_load_en = 1'b0; m_load_addr = '0; m_load_data = '0;
    r_req = 1'b0; r_addr = '0; r_load_en = 1'b0; r_load_addr = '0; r_load_data = '0;

    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_load_collision();
    test_gnt_delay();
    test_max_outstanding();
    test_reset_mid();

    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending responses, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
